// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM state encoding,
// matrix dimensions, the row one-hot drive decode and the column priority encoder.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } kp_state_e;

    // Active-low one-hot row drive for a 2-bit row index
    function automatic logic [KP_ROWS-1:0] row_decode(input logic [1:0] idx);
        logic [KP_ROWS-1:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

    // Index of the lowest column that reads 0 (key closed); 3 when none
    // or only column 3 is closed, so callers must qualify with col != 4'hF.
    function automatic logic [1:0] col_prio(input logic [KP_COLS-1:0] col);
        logic [1:0] idx;
        if (!col[0]) begin
            idx = 2'd0;
        end else if (!col[1]) begin
            idx = 2'd1;
        end else if (!col[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_debounce_cnt.sv
// Scan-tick counter shared by the press and release debounce phases.
// clr_i and inc_i together load 1 (first qualifying sample); clr_i alone
// loads 0; inc_i alone counts up, saturating at TICKS. last_o flags that
// the next increment reaches TICKS, letting the FSM act on that same edge.
module kp_debounce_cnt
    import keypad_pkg::*;
#(
    parameter int unsigned TICKS = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] cnt_o,
    output logic       last_o
);

    localparam logic [3:0] TERM = 4'(TICKS);
    localparam logic [3:0] LAST = 4'(TICKS - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear/load/increment only on scan ticks, otherwise frozen
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (clr_i && inc_i) begin
                cnt_d = 4'd1;
            end else if (clr_i) begin
                cnt_d = 4'd0;
            end else if (inc_i) begin
                cnt_d = (cnt_q >= TERM) ? TERM : cnt_q + 4'd1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q >= LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, valid/ack key handoff, overflow
// pulse and a four-key nibble history for the 7-segment display driver.
//
// Handshake: key_valid rises on the edge a key is accepted and stays high
// until an edge where key_ack=1 is seen with key_valid=1. An accept on that
// same edge takes priority, so key_valid stays high with the new code.
// key_ovf pulses for one clock when an accept replaces a code that was
// still pending and not being acknowledged on that edge.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        key_ovf,
    output logic        key_held,
    output logic [15:0] digits
);

    kp_state_e   state_q, state_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [1:0]  cand_col_q, cand_col_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_ovf_q, key_ovf_d;
    logic        key_held_q, key_held_d;
    logic [15:0] digits_q, digits_d;

    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_last;
    logic [3:0]  deb_cnt;
    logic        accept;
    logic        rel_done;

    // Tick counter used for both press and release qualification
    kp_debounce_cnt #(
        .TICKS (DEBOUNCE_TICKS)
    ) u_deb_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (scan_en),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (deb_cnt),
        .last_o (cnt_last)
    );

    // FSM next state: col is read only on scan ticks, for the row that has
    // been driven since the previous tick; the row is held while a key is
    // being debounced or waiting for release.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        cand_col_d = cand_col_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        accept     = 1'b0;
        rel_done   = 1'b0;
        if (scan_en) begin
            case (state_q)
                ST_SCAN: begin
                    if (col != 4'hF) begin
                        cand_col_d = col_prio(col);
                        cnt_clr    = 1'b1;
                        cnt_inc    = 1'b1;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!col[cand_col_q]) begin
                        if (cnt_last) begin
                            accept  = 1'b1;
                            cnt_clr = 1'b1;
                            state_d = ST_RELEASE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else begin
                        // Bounce: restart detection on the same row
                        cnt_clr = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
                ST_RELEASE: begin
                    if (col == 4'hF) begin
                        if (cnt_last) begin
                            rel_done  = 1'b1;
                            cnt_clr   = 1'b1;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    cnt_clr = 1'b1;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // Key output next state: accept loads code/history and wins over ack
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;
        digits_d    = digits_q;
        key_ovf_d   = 1'b0;
        if (accept) begin
            key_code_d  = {row_idx_q, cand_col_q};
            digits_d    = {digits_q[11:0], row_idx_q, cand_col_q};
            key_valid_d = 1'b1;
            key_ovf_d   = key_valid_q && !key_ack;
        end else if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
        end
        if (accept) begin
            key_held_d = 1'b1;
        end else if (rel_done) begin
            key_held_d = 1'b0;
        end
    end

    // FSM and row-index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_SCAN;
            row_idx_q  <= 2'd0;
            cand_col_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            cand_col_q <= cand_col_d;
        end
    end

    // Key code, handshake, overflow, held flag and history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_ovf_q   <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_ovf_q   <= key_ovf_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    assign row       = row_decode(row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_ovf   = key_ovf_q;
    assign key_held  = key_held_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col from row and a set of
// pressed keys; expected codes, history, latency and handshake behaviour
// come from a key-level model (scan position, pending flag, key queue).
module tb_keypad_scanner;

    localparam int TICKS = 4;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_ovf;
    logic        key_held;
    logic [15:0] digits;

    // Keypad model state
    logic [15:0] pressed;
    logic        bounce_open;

    // Reference model state
    int          n_checks;
    int          n_bad;
    int          scan_pos;
    int          last_row;
    logic        valid_m;
    logic [3:0]  exp_q[$];

    keypad_scanner #(
        .DEBOUNCE_TICKS (TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_ovf   (key_ovf),
        .key_held  (key_held),
        .digits    (digits)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a closed key pulls its column low while its row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c] && !bounce_open) col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_digits();
        logic [15:0] d;
        int n;
        d = 16'h0000;
        n = exp_q.size();
        for (int i = 0; i < 4; i++) begin
            if (n - 1 - i >= 0) d[i*4 +: 4] = exp_q[n-1-i];
        end
        return d;
    endfunction

    function automatic logic [3:0] exp_row(input int idx);
        logic [3:0] r;
        r = 4'hF;
        r[idx % 4] = 1'b0;
        return r;
    endfunction

    // One scan tick every fourth clock; returns at the negedge after the tick edge
    task automatic tick(input logic ack);
        repeat (3) @(negedge clk);
        scan_en = 1'b1;
        key_ack = ack;
        @(negedge clk);
        scan_en = 1'b0;
        key_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_row"}, 16'(row), 16'hE);
        check_eq({tag, "_code"}, 16'(key_code), 16'h0);
        check_eq({tag, "_valid"}, 16'(key_valid), 16'h0);
        check_eq({tag, "_ovf"}, 16'(key_ovf), 16'h0);
        check_eq({tag, "_held"}, 16'(key_held), 16'h0);
        check_eq({tag, "_digits"}, digits, 16'h0000);
    endtask

    task automatic model_reset();
        scan_pos = 0;
        valid_m  = 1'b0;
        exp_q.delete();
    endtask

    // Close the keys in mask and wait for the accept; the expected key is the
    // lowest closed column of the first row with a closed key in scan order.
    task automatic press_keys(input logic [15:0] mask, input logic ack_on_accept);
        int d_found;
        int exp_lat;
        int n;
        logic got;
        logic [3:0] k;
        logic ovf_exp;
        d_found = -1;
        k = 4'h0;
        for (int d = 0; d < 4; d++) begin
            int r;
            r = (scan_pos + d) % 4;
            if (d_found < 0 && mask[r*4 +: 4] != 4'h0) begin
                d_found = d;
                for (int c = 3; c >= 0; c--) begin
                    if (mask[r*4+c]) k = 4'(r*4 + c);
                end
            end
        end
        exp_lat = d_found + TICKS;
        pressed = mask;
        n = 0;
        got = 1'b0;
        while (!got && n < exp_lat + 8) begin
            n++;
            tick(ack_on_accept && (n == exp_lat));
            if (key_held) got = 1'b1;
        end
        ovf_exp = valid_m && !ack_on_accept;
        valid_m = 1'b1;
        exp_q.push_back(k);
        last_row = k[3:2];
        check_eq("press_latency", 16'(n), 16'(exp_lat));
        check_eq("press_code", 16'(key_code), 16'(k));
        check_eq("press_valid", 16'(key_valid), 16'h1);
        check_eq("press_ovf", 16'(key_ovf), 16'(ovf_exp));
        check_eq("press_digits", digits, exp_digits());
        check_eq("press_row_held", 16'(row), 16'(exp_row(last_row)));
        if (ovf_exp) begin
            @(negedge clk);
            check_eq("ovf_one_clk", 16'(key_ovf), 16'h0);
        end
    endtask

    // Open all keys and wait for the release to be qualified
    task automatic release_keys();
        int n;
        pressed = 16'h0000;
        n = 0;
        while (key_held && n < TICKS + 8) begin
            n++;
            tick(1'b0);
        end
        scan_pos = (last_row + 1) % 4;
        check_eq("release_ticks", 16'(n), 16'(TICKS));
        check_eq("release_row", 16'(row), 16'(exp_row(scan_pos)));
        check_eq("release_valid", 16'(key_valid), 16'(valid_m));
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        valid_m = 1'b0;
        check_eq("ack_clears", 16'(key_valid), 16'h0);
    endtask

    initial begin
        logic [15:0] mask;
        int mode;
        int k0;
        n_checks    = 0;
        n_bad       = 0;
        last_row    = 0;
        rst         = 1'b0;
        scan_en     = 1'b0;
        key_ack     = 1'b0;
        pressed     = 16'h0000;
        bounce_open = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;

        // Idle scanning: row rotates one step per tick
        check_eq("idle_row0", 16'(row), 16'hE);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0);
            check_eq("idle_row", 16'(row), 16'(exp_row(i)));
            check_eq("idle_valid", 16'(key_valid), 16'h0);
        end
        scan_pos = 0;

        // Single key r2c1
        press_keys(16'h0001 << 9, 1'b0);
        check_eq("key9_digits", digits, 16'h0009);
        release_keys();
        ack_pulse();

        // Five keys acknowledged one by one
        for (int k = 1; k <= 5; k++) begin
            press_keys(16'h0001 << k, 1'b0);
            release_keys();
            ack_pulse();
        end
        check_eq("five_digits", digits, 16'h2345);

        // Bounce: two closed ticks, one open tick, then stable
        k0 = scan_pos * 4 + 2;
        pressed = 16'h0001 << k0;
        tick(1'b0);
        tick(1'b0);
        check_eq("bounce_no_accept", 16'(key_held), 16'h0);
        bounce_open = 1'b1;
        tick(1'b0);
        check_eq("bounce_open_held", 16'(key_held), 16'h0);
        check_eq("bounce_open_valid", 16'(key_valid), 16'h0);
        bounce_open = 1'b0;
        press_keys(16'h0001 << k0, 1'b0);
        release_keys();
        ack_pulse();

        // Two presses without ack, then ack coinciding with an accept
        press_keys(16'h0001 << 14, 1'b0);
        release_keys();
        press_keys(16'h0001 << 7, 1'b0);
        release_keys();
        press_keys(16'h0001 << 11, 1'b1);
        release_keys();
        ack_pulse();

        // Two keys on one row, then two keys on different rows
        press_keys((16'h0001 << 13) | (16'h0001 << 15), 1'b0);
        release_keys();
        ack_pulse();
        press_keys((16'h0001 << 2) | (16'h0001 << 6), 1'b0);
        release_keys();
        ack_pulse();

        // Reset while debouncing: press discarded, re-detected from row 0
        k0 = scan_pos * 4 + 1;
        pressed = 16'h0001 << k0;
        tick(1'b0);
        tick(1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("rst_debounce");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        press_keys(16'h0001 << k0, 1'b0);

        // Reset while waiting for release: key re-detected after reset
        tick(1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("rst_release");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        press_keys(16'h0001 << k0, 1'b0);
        release_keys();
        ack_pulse();

        // Randomized keys, key pairs and ack timing
        for (int it = 0; it < 10; it++) begin
            mask = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) mask = mask | (16'h0001 << $urandom_range(0, 15));
            mode = $urandom_range(0, 2);
            press_keys(mask, mode == 2);
            release_keys();
            if (mode == 1) ack_pulse();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "time limit reached");
    end

endmodule
